// File: rtl/sdc_sector_arbiter_if.sv
// rtl/sdc_sector_arbiter_if.sv - requester and sd card controller signals around the sector arbiter
// slave is the arbiter's view, master is the surrounding chipset / sd controller view.
interface sdc_sector_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req_rd;
   logic [NREQ*32-1:0] req_sector;
   logic [NREQ-1:0]    req_done;
   logic [NREQ-1:0]    req_err;
   logic [NREQ-1:0]    req_strobe;
   logic [8:0]         req_addr;
   logic [7:0]         req_data;
   logic [NREQ-1:0]    grant;
   logic [NREQ-1:0]    sdc_rd;
   logic [31:0]        sdc_sector;
   logic               sdc_busy;
   logic               sdc_done;
   logic               sdc_byte_in_strobe;
   logic [8:0]         sdc_byte_in_addr;
   logic [7:0]         sdc_byte_in_data;

   modport slave (
      input  req_rd, req_sector, sdc_busy, sdc_done,
             sdc_byte_in_strobe, sdc_byte_in_addr, sdc_byte_in_data,
      output req_done, req_err, req_strobe, req_addr, req_data,
             grant, sdc_rd, sdc_sector
   );

   modport master (
      output req_rd, req_sector, sdc_busy, sdc_done,
             sdc_byte_in_strobe, sdc_byte_in_addr, sdc_byte_in_data,
      input  req_done, req_err, req_strobe, req_addr, req_data,
             grant, sdc_rd, sdc_sector
   );
endinterface

// File: rtl/sdc_sector_arbiter.sv
// rtl/sdc_sector_arbiter.sv - round-robin sharing of the sd card sector-read port between NREQ requesters
// One sector in flight; returned bytes go only to the granted requester, with a per-sector timeout.
module sdc_sector_arbiter #(
   parameter int          NREQ    = 4,
   parameter logic [23:0] TIMEOUT = 24'd8000000
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   sdc_sector_arbiter_if.slave  bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [2:0] {IDLE, ISSUE, XFER, FINISH, RELEASE} state_t;

   state_t          state;
   logic [IW-1:0]   g;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            win_found;
   logic [9:0]      byte_cnt;
   logic [9:0]      byte_cnt_nx;
   logic [23:0]     tmo_cnt;
   logic            byte_hit;

   // Scan downward so the candidate closest to last_grant+1 is the one left standing.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NREQ);
         if (bus.req_rd[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign byte_hit    = ((state == ISSUE) || (state == XFER)) && bus.sdc_byte_in_strobe;
   assign byte_cnt_nx = (byte_hit && (byte_cnt != 10'h3ff)) ? byte_cnt + 10'd1 : byte_cnt;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         g              <= '0;
         last_grant     <= IW'(NREQ - 1);
         byte_cnt       <= '0;
         tmo_cnt        <= '0;
         bus.req_done   <= '0;
         bus.req_err    <= '0;
         bus.req_strobe <= '0;
         bus.req_addr   <= '0;
         bus.req_data   <= '0;
         bus.grant      <= '0;
         bus.sdc_rd     <= '0;
         bus.sdc_sector <= '0;
      end else begin
         bus.req_done   <= '0;
         bus.req_err    <= '0;
         bus.req_strobe <= '0;
         byte_cnt       <= byte_cnt_nx;
         if (byte_hit) begin
            bus.req_strobe <= ONE << g;
            bus.req_addr   <= bus.sdc_byte_in_addr;
            bus.req_data   <= bus.sdc_byte_in_data;
         end
         case (state)
            IDLE: begin
               if (win_found && !bus.sdc_busy) begin
                  g              <= win_idx;
                  last_grant     <= win_idx;
                  bus.grant      <= ONE << win_idx;
                  bus.sdc_rd     <= ONE << win_idx;
                  bus.sdc_sector <= bus.req_sector[32*win_idx +: 32];
                  byte_cnt       <= '0;
                  tmo_cnt        <= '0;
                  state          <= ISSUE;
               end
            end
            ISSUE, XFER: begin
               // A done arriving before busy was seen is handled as a complete transfer.
               if (bus.sdc_done) begin
                  bus.sdc_rd   <= '0;
                  bus.req_done <= ONE << g;
                  bus.req_err  <= (byte_cnt_nx != 10'd512) ? (ONE << g) : '0;
                  state        <= FINISH;
               end else if (tmo_cnt == TIMEOUT - 24'd1) begin
                  bus.sdc_rd   <= '0;
                  bus.req_done <= ONE << g;
                  bus.req_err  <= ONE << g;
                  state        <= RELEASE;
               end else begin
                  tmo_cnt <= tmo_cnt + 24'd1;
                  if ((state == ISSUE) && bus.sdc_busy) begin
                     bus.sdc_rd <= '0;
                     state      <= XFER;
                  end
               end
            end
            FINISH: state <= RELEASE;
            RELEASE: begin
               if (!bus.req_rd[g]) begin
                  bus.grant <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/sdc_sector_arbiter.md
Name: sdc_sector_arbiter

Overview:
- Shares the single sd card sector-read interface (sdc_rd/sdc_sector/sdc_busy/sdc_done/byte stream) between up to NREQ independent requesters, e.g. floppy drives DF0-DF3.
- Round-robin arbitration; one 512-byte sector transfer in flight at a time.
- Each returned byte is routed only to the granted requester.
- Sits between the floppy controllers inside the chipset and the sd card controller.

Parameters:
NREQ, 4, number of requesters (sdc_rd is one-hot, one bit per image slot)
TIMEOUT, 24'd8000000, clk_sys cycles allowed per sector before abort (~0.28 s at 28.6875 MHz)

Ports:
clk_sys  in  1  system clock (28.6875 MHz)
reset  in  1  asynchronous, active-high
req_rd  in  NREQ  per-requester read request, level, held until req_done
req_sector  in  NREQ*32  per-requester sector number; requester i uses bits [32*i+31:32*i]; stable while req_rd high
req_done  out  NREQ  one-cycle completion pulse
req_err  out  NREQ  one-cycle error pulse, coincident with req_done
req_strobe  out  NREQ  per-requester byte strobe
req_addr  out  9  byte offset in sector, shared
req_data  out  8  byte data, shared
grant  out  NREQ  one-hot current owner, 0 when idle
sdc_rd  out  NREQ  one-hot read request to sd card controller
sdc_sector  out  32  sector number to sd card controller
sdc_busy  in  1  controller busy
sdc_done  in  1  controller sector-complete pulse
sdc_byte_in_strobe  in  1  byte valid
sdc_byte_in_addr  in  9  byte offset
sdc_byte_in_data  in  8  byte data

Behaviour:
- Reset: all outputs 0; state IDLE; last-grant pointer = NREQ-1, so index 0 has first priority; byte counter and timeout counter cleared. Assertion mid-transfer aborts immediately with no pulses. After release the block restarts from IDLE.
- States: IDLE, ISSUE, XFER, FINISH, RELEASE.
- IDLE:
  - Waits for any req_rd bit while sdc_busy = 0.
  - Winner is the first set bit scanning upward from last_grant+1, wrapping modulo NREQ.
  - Latch winner index g and req_sector[g]; set grant[g] and last_grant=g; go to ISSUE next cycle.
- ISSUE:
  - sdc_rd[g]=1; sdc_sector=latched value.
  - sdc_busy sampled high: clear sdc_rd and go to XFER.
  - sdc_done seen while still in ISSUE: treat as XFER followed by done.
- XFER:
  - sdc_byte_in_strobe is registered and forwarded to req_strobe[g], together with req_addr/req_data, with 1-cycle latency. Other req_strobe bits stay 0.
  - Byte counter (10-bit, saturating at 1023) increments per strobe.
  - sdc_done: go to FINISH.
- FINISH: one cycle. req_done[g]=1; req_err[g]=1 if byte count != 512. The final byte's delayed strobe precedes or coincides with req_done.
- RELEASE:
  - grant held; waits for req_rd[g]=0, then grant=0 and return to IDLE.
  - A requester that keeps req_rd high blocks only itself. Re-arbitration needs a low cycle, guaranteeing fairness.
- Timeout:
  - Counter runs in ISSUE and XFER, cleared on leaving IDLE.
  - Reaching TIMEOUT: drop sdc_rd, pulse req_done[g] and req_err[g], go to RELEASE.
  - Late sdc_done or bytes after timeout are ignored.
- Requester drops req_rd mid-transfer: no abort. Transfer completes, req_done still pulses, RELEASE exits immediately.
- Byte strobes outside XFER/ISSUE are dropped; no req_strobe is generated.
- Simultaneous new req_rd and transfer completion: the new request is considered only in IDLE.
- sdc_sector holds its last value when idle; sdc_rd is never multi-hot.

Test Plan:
- Single request: req_rd=4'b0001, sector 0x00000123 → sdc_rd=0001, sdc_sector=0x123. Feed busy + 512 strobes (addr 0..511, data=addr[7:0]) → req_strobe[0] ×512 each 1 cycle delayed with matching addr/data; then req_done[0] pulse, req_err=0.
- Round robin: req_rd=4'b1111 held, each requester drops req_rd for 1 cycle after its done and reasserts → grant order 0,1,2,3,0.
- Short sector: only 500 strobes before sdc_done → req_done[2] and req_err[2] on the same cycle; byte counter cleared for next grant.
- Timeout with TIMEOUT=1000: sdc_busy never rises → sdc_rd drops at cycle ~1000, req_done+req_err pulse; a later sdc_done produces no pulse.
- Isolation: requester 1 granted, requester 3 requesting → zero req_strobe[3] during transfer; requester 3 served next.
- Reset asserted at byte 200 → all outputs 0 next edge; after release, req_rd=0001 serves index 0 normally.
